// File: rtl/multi_cycle_ctrl_if.sv
// Control bus between the multi-cycle controller (master) and the datapath (slave):
// instruction fields and ALU flag in, every datapath control out.
interface multi_cycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       PCWr;
  logic       IRWr;
  logic       RegWr;
  logic       MemWr;
  logic [1:0] RegDst;
  logic       ALUSrc;
  logic [1:0] ExtOp;
  logic [2:0] ALUOp;
  logic       MemtoReg;
  logic [1:0] NPCOp;
  logic       instr_done;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output PCWr, IRWr, RegWr, MemWr, RegDst, ALUSrc, ExtOp, ALUOp,
           MemtoReg, NPCOp, instr_done, state
  );

  modport slave (
    output op, funct, zero,
    input  PCWr, IRWr, RegWr, MemWr, RegDst, ALUSrc, ExtOp, ALUOp,
           MemtoReg, NPCOp, instr_done, state
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset core: sequences each instruction
// and drives all datapath controls from the current state plus op/funct.
module multi_cycle_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  multi_cycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXE       = 4'd2,
    S_ALU_WB    = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_MEM_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    K_NONE  = 3'd0,
    K_RTYPE = 3'd1,
    K_IMM   = 3'd2,
    K_LW    = 3'd3,
    K_SW    = 3'd4,
    K_BEQ   = 3'd5,
    K_J     = 3'd6
  } kind_e;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
  } dp_ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  // MEM_READ dwell ends when the counter reaches MEM_LAT-1
  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 32'd1);

  function automatic kind_e decode_kind(input logic [5:0] op, input logic [5:0] funct);
    kind_e k;
    case (op)
      OP_RTYPE: begin
        if ((funct == FN_ADDU) || (funct == FN_SUBU)) k = K_RTYPE;
        else k = K_NONE;
      end
      OP_ORI, OP_ADDIU, OP_LUI: k = K_IMM;
      OP_LW:  k = K_LW;
      OP_SW:  k = K_SW;
      OP_BEQ: k = K_BEQ;
      OP_J:   k = K_J;
      default: k = K_NONE;
    endcase
    return k;
  endfunction

  function automatic dp_ctrl_t decode_dp(input logic [5:0] op, input logic [5:0] funct);
    dp_ctrl_t c;
    c = '{alu_src: 1'b0, ext_op: 2'b00, alu_op: 3'b000};
    case (op)
      OP_RTYPE: begin
        if (funct == FN_SUBU) c.alu_op = 3'b001;
        else c.alu_op = 3'b000;
      end
      OP_ORI:   c = '{alu_src: 1'b1, ext_op: 2'b00, alu_op: 3'b010};
      OP_ADDIU: c = '{alu_src: 1'b1, ext_op: 2'b01, alu_op: 3'b000};
      OP_LUI:   c = '{alu_src: 1'b1, ext_op: 2'b10, alu_op: 3'b000};
      OP_LW, OP_SW: c = '{alu_src: 1'b1, ext_op: 2'b01, alu_op: 3'b000};
      OP_BEQ:   c = '{alu_src: 1'b0, ext_op: 2'b01, alu_op: 3'b001};
      default:  c = '{alu_src: 1'b0, ext_op: 2'b00, alu_op: 3'b000};
    endcase
    return c;
  endfunction

  state_e     state_q;
  state_e     state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  kind_e      kind_s;
  dp_ctrl_t   dp_s;

  assign kind_s = decode_kind(bus.op, bus.funct);
  assign dp_s   = decode_dp(bus.op, bus.funct);

  always_comb begin
    state_d = S_FETCH;
    cnt_d   = 4'd0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (kind_s)
          K_RTYPE, K_IMM: state_d = S_EXE;
          K_LW, K_SW:     state_d = S_MEM_ADDR;
          K_BEQ:          state_d = S_BRANCH;
          K_J:            state_d = S_JUMP;
          default:        state_d = S_FETCH;
        endcase
      end
      S_EXE: state_d = S_ALU_WB;
      S_MEM_ADDR: begin
        if (kind_s == K_LW) state_d = S_MEM_READ;
        else state_d = S_MEM_WRITE;
      end
      S_MEM_READ: begin
        if (cnt_q == LAT_LAST) begin
          state_d = S_MEM_WB;
          cnt_d   = 4'd0;
        end else begin
          state_d = S_MEM_READ;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore controls; per-instruction ALU/extender fields persist DECODE..last state
  always_comb begin
    bus.PCWr       = 1'b0;
    bus.IRWr       = 1'b0;
    bus.RegWr      = 1'b0;
    bus.MemWr      = 1'b0;
    bus.RegDst     = 2'b00;
    bus.ALUSrc     = 1'b0;
    bus.ExtOp      = 2'b00;
    bus.ALUOp      = 3'b000;
    bus.MemtoReg   = 1'b0;
    bus.NPCOp      = 2'b00;
    bus.instr_done = 1'b0;
    bus.state      = 4'd0;
    if (reset) begin
      bus.state = 4'd0;
    end else begin
      bus.state = state_q;
      case (state_q)
        S_FETCH: begin
          bus.PCWr = 1'b1;
          bus.IRWr = 1'b1;
        end
        S_DECODE: begin
          {bus.ALUSrc, bus.ExtOp, bus.ALUOp} = dp_s;
          bus.instr_done = (kind_s == K_NONE);
        end
        S_EXE, S_MEM_ADDR, S_MEM_READ: begin
          {bus.ALUSrc, bus.ExtOp, bus.ALUOp} = dp_s;
        end
        S_ALU_WB: begin
          {bus.ALUSrc, bus.ExtOp, bus.ALUOp} = dp_s;
          bus.RegWr      = 1'b1;
          bus.RegDst     = (kind_s == K_RTYPE) ? 2'b01 : 2'b00;
          bus.instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          {bus.ALUSrc, bus.ExtOp, bus.ALUOp} = dp_s;
          bus.MemWr      = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_MEM_WB: begin
          {bus.ALUSrc, bus.ExtOp, bus.ALUOp} = dp_s;
          bus.RegWr      = 1'b1;
          bus.MemtoReg   = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_BRANCH: begin
          {bus.ALUSrc, bus.ExtOp, bus.ALUOp} = dp_s;
          bus.NPCOp      = 2'b01;
          bus.PCWr       = bus.zero;
          bus.instr_done = 1'b1;
        end
        S_JUMP: begin
          {bus.ALUSrc, bus.ExtOp, bus.ALUOp} = dp_s;
          bus.NPCOp      = 2'b10;
          bus.PCWr       = 1'b1;
          bus.instr_done = 1'b1;
        end
        default: begin
          bus.PCWr = 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl (MEM_LAT=3): walks each supported
// instruction through its state sequence and checks every control per cycle.
module tb_multi_cycle_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl #(.MEM_LAT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] obs_s;
  assign obs_s = {bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr, bus.RegDst, bus.ALUSrc,
                  bus.ExtOp, bus.ALUOp, bus.MemtoReg, bus.NPCOp, bus.instr_done, bus.state};

  // Field order: PCWr IRWr RegWr MemWr RegDst ALUSrc ExtOp ALUOp MemtoReg NPCOp done state
  function automatic logic [19:0] pk(input logic p, input logic i, input logic r, input logic m,
                                     input logic [1:0] rd, input logic as, input logic [1:0] ex,
                                     input logic [2:0] ao, input logic mr, input logic [1:0] np,
                                     input logic d, input logic [3:0] st);
    return {p, i, r, m, rd, as, ex, ao, mr, np, d, st};
  endfunction

  task automatic chk(input string tag, input logic [19:0] exp);
    checks++;
    assert (obs_s === exp) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs_s, exp);
    end
  endtask

  task automatic step(input string tag, input logic [19:0] exp);
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  task automatic set_in(input logic [5:0] o, input logic [5:0] f, input logic z);
    bus.op    = o;
    bus.funct = f;
    bus.zero  = z;
  endtask

  logic [19:0] fetch_v;
  logic [19:0] zero_v;

  initial begin
    checks  = 0;
    errors  = 0;
    fetch_v = pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 4'd0);
    zero_v  = 20'd0;
    reset   = 1'b1;
    set_in(6'b000000, 6'b100001, 1'b0);
    step("rst1", zero_v);
    step("rst2", zero_v);
    step("rst3", zero_v);
    reset = 1'b0;
    #1;
    chk("fetch_after_rst", fetch_v);

    // addu
    step("addu_dec", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 4'd1));
    step("addu_exe", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 4'd2));
    step("addu_wb",  pk(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b1, 4'd3));
    step("addu_fetch", fetch_v);

    // subu
    set_in(6'b000000, 6'b100011, 1'b0);
    step("subu_dec", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b001, 1'b0, 2'b00, 1'b0, 4'd1));
    step("subu_exe", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b001, 1'b0, 2'b00, 1'b0, 4'd2));
    step("subu_wb",  pk(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 3'b001, 1'b0, 2'b00, 1'b1, 4'd3));
    step("subu_fetch", fetch_v);

    // lui
    set_in(6'b001111, 6'b000000, 1'b0);
    step("lui_dec", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 3'b000, 1'b0, 2'b00, 1'b0, 4'd1));
    step("lui_exe", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 3'b000, 1'b0, 2'b00, 1'b0, 4'd2));
    step("lui_wb",  pk(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10, 3'b000, 1'b0, 2'b00, 1'b1, 4'd3));
    step("lui_fetch", fetch_v);

    // ori
    set_in(6'b001101, 6'b100001, 1'b0);
    step("ori_dec", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 3'b010, 1'b0, 2'b00, 1'b0, 4'd1));
    step("ori_exe", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 3'b010, 1'b0, 2'b00, 1'b0, 4'd2));
    step("ori_wb",  pk(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b00, 3'b010, 1'b0, 2'b00, 1'b1, 4'd3));
    step("ori_fetch", fetch_v);

    // addiu
    set_in(6'b001001, 6'b000000, 1'b0);
    step("addiu_dec", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 3'b000, 1'b0, 2'b00, 1'b0, 4'd1));
    step("addiu_exe", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 3'b000, 1'b0, 2'b00, 1'b0, 4'd2));
    step("addiu_wb",  pk(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 3'b000, 1'b0, 2'b00, 1'b1, 4'd3));
    step("addiu_fetch", fetch_v);

    // lw, MEM_LAT=3: 0,1,4,5,5,5,7
    set_in(6'b100011, 6'b000000, 1'b0);
    step("lw_dec",   pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 3'b000, 1'b0, 2'b00, 1'b0, 4'd1));
    step("lw_addr",  pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 3'b000, 1'b0, 2'b00, 1'b0, 4'd4));
    step("lw_rd1",   pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 3'b000, 1'b0, 2'b00, 1'b0, 4'd5));
    step("lw_rd2",   pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 3'b000, 1'b0, 2'b00, 1'b0, 4'd5));
    step("lw_rd3",   pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 3'b000, 1'b0, 2'b00, 1'b0, 4'd5));
    step("lw_wb",    pk(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 3'b000, 1'b1, 2'b00, 1'b1, 4'd7));
    step("lw_fetch", fetch_v);

    // sw
    set_in(6'b101011, 6'b000000, 1'b0);
    step("sw_dec",   pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 3'b000, 1'b0, 2'b00, 1'b0, 4'd1));
    step("sw_addr",  pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 3'b000, 1'b0, 2'b00, 1'b0, 4'd4));
    step("sw_wr",    pk(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b01, 3'b000, 1'b0, 2'b00, 1'b1, 4'd6));
    step("sw_fetch", fetch_v);

    // beq taken
    set_in(6'b000100, 6'b000000, 1'b1);
    step("beq1_dec", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 3'b001, 1'b0, 2'b00, 1'b0, 4'd1));
    step("beq1_br",  pk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 3'b001, 1'b0, 2'b01, 1'b1, 4'd8));
    step("beq1_fetch", fetch_v);

    // beq not taken
    set_in(6'b000100, 6'b000000, 1'b0);
    step("beq0_dec", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 3'b001, 1'b0, 2'b00, 1'b0, 4'd1));
    step("beq0_br",  pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 3'b001, 1'b0, 2'b01, 1'b1, 4'd8));
    step("beq0_fetch", fetch_v);

    // j
    set_in(6'b000010, 6'b000000, 1'b0);
    step("j_dec",  pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 4'd1));
    step("j_jmp",  pk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b10, 1'b1, 4'd9));
    step("j_fetch", fetch_v);

    // reset asserted in the middle of MEM_READ
    set_in(6'b100011, 6'b000000, 1'b0);
    step("lwr_dec",  pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 3'b000, 1'b0, 2'b00, 1'b0, 4'd1));
    step("lwr_addr", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 3'b000, 1'b0, 2'b00, 1'b0, 4'd4));
    step("lwr_rd1",  pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 3'b000, 1'b0, 2'b00, 1'b0, 4'd5));
    reset = 1'b1;
    #1;
    chk("lwr_rst_comb", zero_v);
    step("lwr_rst_edge", zero_v);
    reset = 1'b0;
    #1;
    chk("lwr_after_rst", fetch_v);

    // unsupported opcode: 0,1,0 with instr_done in DECODE only
    set_in(6'b111111, 6'b000000, 1'b0);
    step("bad_op_dec", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b1, 4'd1));
    step("bad_op_fetch", fetch_v);

    // R-type with unsupported funct
    set_in(6'b000000, 6'b000000, 1'b0);
    step("bad_fn_dec", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b1, 4'd1));
    step("bad_fn_fetch", fetch_v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
Multi-cycle control unit for the MIPS-subset CPU core. It sequences fetch/decode/execute/memory/writeback through a Moore-style FSM. It drives every datapath control: PC/IR write enables, register file, data memory, ALU, next-PC selector and the immediate extender mode (ExtOp). It sits beside the datapath and reads op/funct from the instruction register and zero from the ALU.

Parameters:
MEM_LAT, 1, cycles spent in MEM_READ per lw (≥1); internal counter width 4 bits, so legal range 1..15.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
op  in  6  IR[31:26]; valid from DECODE until next FETCH
funct  in  6  IR[5:0]; same validity as op
zero  in  1  ALU zero flag from EXE-class state of current instruction
PCWr  out  1  PC write enable
IRWr  out  1  instruction register write enable
RegWr  out  1  register file write enable
MemWr  out  1  data memory write enable
RegDst  out  2  write-register select: 00 rt, 01 rd
ALUSrc  out  1  ALU B select: 0 register, 1 extended immediate
ExtOp  out  2  extender mode: 00 zero-ext, 01 sign-ext, 10 imm<<16
ALUOp  out  3  000 add, 001 sub, 010 or
MemtoReg  out  1  writeback select: 0 ALU result, 1 memory data
NPCOp  out  2  00 PC+4, 01 branch target, 10 jump target
instr_done  out  1  one-cycle pulse in last state of each instruction
state  out  4  current FSM state (debug/verification)

Behaviour:
- Decided interface fact: one clock; reset is synchronous and active-high (clk, reset).
- reset high at a clock edge → state=FETCH, wait counter=0. Applies mid-instruction; any in-flight instruction is abandoned.
- While reset is high, all write enables (PCWr, IRWr, RegWr, MemWr) and instr_done are forced 0. All other outputs are 0.
- Supported opcodes:
  - R-type op=000000, funct 100001 addu or 100011 subu.
  - ori 001101; addiu 001001; lui 001111; lw 100011; sw 101011; beq 000100; j 000010.
- States and encodings:
  - FETCH(0): PCWr=1, IRWr=1, NPCOp=00. → DECODE.
  - DECODE(1): all enables 0.
    - lw/sw → MEM_ADDR.
    - R-type/ori/addiu/lui → EXE.
    - beq → BRANCH.
    - j → JUMP.
    - Any other op, or R-type with unsupported funct → FETCH with instr_done=1 (NOP; no writes).
  - EXE(2): ALUSrc/ALUOp per instruction. → ALU_WB.
  - ALU_WB(3): RegWr=1; RegDst=01 for R-type, else 00; MemtoReg=0; instr_done=1. → FETCH.
  - MEM_ADDR(4): ALUSrc=1, ALUOp=000, ExtOp=01. lw → MEM_READ; sw → MEM_WRITE.
  - MEM_READ(5): counter increments each cycle. Move to MEM_WB when counter reaches MEM_LAT-1; counter clears on exit.
  - MEM_WRITE(6): MemWr=1 for exactly one cycle, instr_done=1. → FETCH.
  - MEM_WB(7): RegWr=1, RegDst=00, MemtoReg=1, instr_done=1. → FETCH.
  - BRANCH(8): ALUSrc=0, ALUOp=001, NPCOp=01, PCWr=zero, instr_done=1. → FETCH.
  - JUMP(9): NPCOp=10, PCWr=1, instr_done=1. → FETCH.
  - Encodings 10–15 are unreachable; if entered, they act as FETCH-next with no enables.
- Per-instruction datapath controls: outputs are combinational from state and op/funct. ExtOp, ALUSrc and ALUOp hold their per-instruction value from DECODE through the final state.
  - addu: ALUOp=000, ALUSrc=0.
  - subu: ALUOp=001, ALUSrc=0.
  - ori: ALUOp=010, ALUSrc=1, ExtOp=00.
  - addiu: ALUOp=000, ALUSrc=1, ExtOp=01.
  - lui: ALUOp=000, ALUSrc=1, ExtOp=10 (rs=$0 by encoding).
  - lw/sw/beq: ExtOp=01.
- Latency in cycles, including FETCH:
  - R/ori/addiu/lui: 4.
  - lw: 4+MEM_LAT.
  - sw: 4.
  - beq and j: 3.
  - Unsupported: 2.
- Write-enable invariants:
  - At most one of RegWr/MemWr is high in any cycle.
  - PCWr is never high outside FETCH/BRANCH/JUMP.
  - IRWr is high only in FETCH.

Test Plan:
- Reset, then hold reset 3 cycles → state=0, all enables 0. Release → cycle 1: PCWr=IRWr=1.
- addu (op=0, funct=100001) → states 0,1,2,3. In state 3: RegWr=1, RegDst=01, ALUOp=000, instr_done=1.
- lui op=001111 → ExtOp=10, ALUSrc=1 in states 1–3. ori → ExtOp=00, ALUOp=010. addiu → ExtOp=01.
- lw with MEM_LAT=3 → states 0,1,4,5,5,5,7. MemtoReg=1, RegWr=1 only in state 7; 7-cycle total. sw → MemWr=1 only in state 6.
- beq with zero=1 → PCWr=1, NPCOp=01 in state 8. Repeat with zero=0 → PCWr=0. j → PCWr=1, NPCOp=10 in state 9.
- Assert reset during MEM_READ → next state 0, no RegWr. Issue op=111111 → 0,1,0 with instr_done=1 and no enables in state 1.
